resync_cmd_decoder: RTL and testbench

Parametrised successor of the serial ReSync fast-command unit. It deframes the ReSync serial line into 10-bit command frames, checks parity, and decodes an opcode and channel mask. It drives per-channel ADC reset/calibration pulses, DTU/I2C/ATU reset pulses, sync-mode level, flush/PLL/BC0 strobes and a programmable CATIA test pulse. It sits between the ReSync pad and the DTU/ADC/serializer resets in the top datapath; the TMR wrapper is generated around it.

---
 rtl/resync_cmd_decoder_pkg.sv | 33 +++
 rtl/resync_cmd_decoder_pulse_gen.sv | 32 +++
 rtl/resync_cmd_decoder.sv | 157 +++++++++++++++
 tb/tb_resync_cmd_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/resync_cmd_decoder_pkg.sv
// Shared constants and types for the ReSync fast-command decoder.
package resync_cmd_decoder_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ARG_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FIX_W   = 16;

  localparam logic [OP_W-1:0] OP_NOP      = 4'h0;
  localparam logic [OP_W-1:0] OP_ADC_RST  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADC_CAL  = 4'h2;
  localparam logic [OP_W-1:0] OP_DTU_RST  = 4'h3;
  localparam logic [OP_W-1:0] OP_I2C_RST  = 4'h4;
  localparam logic [OP_W-1:0] OP_ATU_RST  = 4'h5;
  localparam logic [OP_W-1:0] OP_SYNC_ON  = 4'h6;
  localparam logic [OP_W-1:0] OP_SYNC_OFF = 4'h7;
  localparam logic [OP_W-1:0] OP_FLUSH    = 4'h8;
  localparam logic [OP_W-1:0] OP_PLL_LOCK = 4'h9;
  localparam logic [OP_W-1:0] OP_TP       = 4'hA;
  localparam logic [OP_W-1:0] OP_BC0      = 4'hB;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Opcodes 0xC-0xF are reserved and rejected.
  function automatic logic op_defined(input logic [OP_W-1:0] op);
    return op <= OP_BC0;
  endfunction

endpackage

// File: rtl/resync_cmd_decoder_pulse_gen.sv
// Retriggerable fixed/run-time length pulse generator; len==0 never fires.
module resync_cmd_decoder_pulse_gen #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             trig,
  input  logic             retrig,
  input  logic [LEN_W-1:0] len,
  output logic             pulse
);

  logic [LEN_W-1:0] cnt;

  // Load on trigger (only when idle unless retrigger allowed), then count down.
  always_ff @(posedge clock) begin
    if (rst) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else if (trig && (len != '0) && (retrig || !pulse)) begin
      pulse <= 1'b1;
      cnt   <= len - LEN_W'(1);
    end else if (pulse) begin
      if (cnt == '0) begin
        pulse <= 1'b0;
      end else begin
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/resync_cmd_decoder.sv
// ReSync serial deframer, parity check and fast-command decoder.
module resync_cmd_decoder
  import resync_cmd_decoder_pkg::*;
#(
  parameter int unsigned N_ADC   = 2,
  parameter int unsigned RST_LEN = 8,
  parameter int unsigned CAL_LEN = 4,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             serial_in,
  input  logic [7:0]       tp_len,
  output logic [N_ADC-1:0] adc_rst_b,
  output logic [N_ADC-1:0] adc_cal,
  output logic             dtu_rst_b,
  output logic             i2c_rst_b,
  output logic             atu_rst_b,
  output logic             dtu_sync_mode,
  output logic             dtu_flush,
  output logic             pll_lock_start,
  output logic             catia_tp,
  output logic             bc0_mark,
  output logic             cmd_valid,
  output logic             cmd_err,
  output logic [OP_W-1:0]  last_op,
  output logic [ERR_W-1:0] err_count
);

  state_e             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] sr;
  logic               done;

  logic [OP_W-1:0]    op_c;
  logic [N_ADC-1:0]   mask_c;
  logic               accept_c;
  logic               reject_c;
  logic [N_ADC-1:0]   adc_rst_trig_c;
  logic [N_ADC-1:0]   adc_cal_trig_c;
  logic [N_ADC-1:0]   adc_rst_p;
  logic               dtu_p;
  logic               i2c_p;
  logic               atu_p;

  assign op_c   = sr[FRAME_W-2 -: OP_W];
  assign mask_c = sr[1 +: N_ADC];

  // Deframer: start bit enters SHIFT, nine more bits complete the frame.
  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sr      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (serial_in) begin
            state   <= ST_SHIFT;
            bit_cnt <= CNT_W'(1);
            sr      <= {sr[FRAME_W-2:0], serial_in};
          end
        end
        ST_SHIFT: begin
          sr <= {sr[FRAME_W-2:0], serial_in};
          if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            done    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decode the completed frame during the cycle after its last bit.
  always_comb begin
    accept_c       = 1'b0;
    reject_c       = 1'b0;
    adc_rst_trig_c = '0;
    adc_cal_trig_c = '0;
    if (done) begin
      accept_c = (~^sr) && op_defined(op_c) &&
                 !(((op_c == OP_ADC_RST) || (op_c == OP_ADC_CAL)) && (mask_c == '0));
      reject_c = !accept_c;
    end
    if (accept_c && (op_c == OP_ADC_RST)) adc_rst_trig_c = mask_c;
    if (accept_c && (op_c == OP_ADC_CAL)) adc_cal_trig_c = mask_c;
  end

  // Status, level and single-cycle strobe outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      cmd_valid      <= 1'b0;
      cmd_err        <= 1'b0;
      last_op        <= '0;
      err_count      <= '0;
      dtu_sync_mode  <= 1'b0;
      dtu_flush      <= 1'b0;
      pll_lock_start <= 1'b0;
      bc0_mark       <= 1'b0;
    end else begin
      cmd_valid      <= accept_c;
      cmd_err        <= reject_c;
      dtu_flush      <= accept_c && (op_c == OP_FLUSH);
      pll_lock_start <= accept_c && (op_c == OP_PLL_LOCK);
      bc0_mark       <= accept_c && (op_c == OP_BC0);
      if (accept_c) last_op <= op_c;
      if (reject_c && (err_count != '1)) err_count <= err_count + ERR_W'(1);
      if (accept_c && (op_c == OP_SYNC_ON)) begin
        dtu_sync_mode <= 1'b1;
      end else if (accept_c && (op_c == OP_SYNC_OFF)) begin
        dtu_sync_mode <= 1'b0;
      end
    end
  end

  for (genvar ch = 0; ch < N_ADC; ch++) begin : g_adc
    resync_cmd_decoder_pulse_gen #(.LEN_W(FIX_W)) u_rst (
      .clock(clock), .rst(rst), .trig(adc_rst_trig_c[ch]), .retrig(1'b1),
      .len(FIX_W'(RST_LEN)), .pulse(adc_rst_p[ch])
    );
    resync_cmd_decoder_pulse_gen #(.LEN_W(FIX_W)) u_cal (
      .clock(clock), .rst(rst), .trig(adc_cal_trig_c[ch]), .retrig(1'b1),
      .len(FIX_W'(CAL_LEN)), .pulse(adc_cal[ch])
    );
  end

  resync_cmd_decoder_pulse_gen #(.LEN_W(FIX_W)) u_dtu (
    .clock(clock), .rst(rst), .trig(accept_c && (op_c == OP_DTU_RST)), .retrig(1'b1),
    .len(FIX_W'(RST_LEN)), .pulse(dtu_p)
  );
  resync_cmd_decoder_pulse_gen #(.LEN_W(FIX_W)) u_i2c (
    .clock(clock), .rst(rst), .trig(accept_c && (op_c == OP_I2C_RST)), .retrig(1'b1),
    .len(FIX_W'(RST_LEN)), .pulse(i2c_p)
  );
  resync_cmd_decoder_pulse_gen #(.LEN_W(FIX_W)) u_atu (
    .clock(clock), .rst(rst), .trig(accept_c && (op_c == OP_ATU_RST)), .retrig(1'b1),
    .len(FIX_W'(RST_LEN)), .pulse(atu_p)
  );
  // Test pulse ignores new TP commands while active.
  resync_cmd_decoder_pulse_gen #(.LEN_W(8)) u_tp (
    .clock(clock), .rst(rst), .trig(accept_c && (op_c == OP_TP)), .retrig(1'b0),
    .len(tp_len), .pulse(catia_tp)
  );

  assign adc_rst_b = ~adc_rst_p;
  assign dtu_rst_b = ~dtu_p;
  assign i2c_rst_b = ~i2c_p;
  assign atu_rst_b = ~atu_p;

endmodule

// File: tb/tb_resync_cmd_decoder.sv
// Scoreboard bench for resync_cmd_decoder: per-cycle output vector against a timeline model.
module tb_resync_cmd_decoder;

  localparam int unsigned N_ADC   = 2;
  localparam int unsigned RST_LEN = 8;
  localparam int unsigned CAL_LEN = 12;
  localparam int unsigned ERR_W   = 8;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             serial_in = 1'b0;
  logic [7:0]       tp_len = 8'd0;
  logic [N_ADC-1:0] adc_rst_b, adc_cal;
  logic             dtu_rst_b, i2c_rst_b, atu_rst_b, dtu_sync_mode, dtu_flush;
  logic             pll_lock_start, catia_tp, bc0_mark, cmd_valid, cmd_err;
  logic [3:0]       last_op;
  logic [ERR_W-1:0] err_count;

  resync_cmd_decoder #(.N_ADC(N_ADC), .RST_LEN(RST_LEN), .CAL_LEN(CAL_LEN), .ERR_W(ERR_W)) dut (
    .clock(clock), .rst(rst), .serial_in(serial_in), .tp_len(tp_len),
    .adc_rst_b(adc_rst_b), .adc_cal(adc_cal), .dtu_rst_b(dtu_rst_b),
    .i2c_rst_b(i2c_rst_b), .atu_rst_b(atu_rst_b), .dtu_sync_mode(dtu_sync_mode),
    .dtu_flush(dtu_flush), .pll_lock_start(pll_lock_start), .catia_tp(catia_tp),
    .bc0_mark(bc0_mark), .cmd_valid(cmd_valid), .cmd_err(cmd_err),
    .last_op(last_op), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   due;
    logic valid;
    logic err;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Model: pulse windows [s, e) in edge numbers, strobe edges, level state.
  int   rst_s[N_ADC], rst_e[N_ADC], cal_s[N_ADC], cal_e[N_ADC];
  int   dtu_s, dtu_e, i2c_s, i2c_e, atu_s, atu_e, tp_s, tp_e;
  int   flush_t, pll_t, bc0_t, sync_t;
  logic sync_prev, sync_new;
  logic [3:0] last_op_m;
  int   errc_m;

  function automatic logic win(input int s, input int e, input int c);
    return (s <= c) && (c < e);
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < N_ADC; ch++) begin
      rst_s[ch] = 0; rst_e[ch] = 0; cal_s[ch] = 0; cal_e[ch] = 0;
    end
    dtu_s = 0; dtu_e = 0; i2c_s = 0; i2c_e = 0; atu_s = 0; atu_e = 0;
    tp_s = 0; tp_e = 0;
    flush_t = -1; pll_t = -1; bc0_t = -1; sync_t = 0;
    sync_prev = 1'b0; sync_new = 1'b0;
    last_op_m = 4'h0; errc_m = 0;
    sbq.delete();
  endtask

  task automatic check_outputs();
    logic [N_ADC-1:0] e_rst, e_cal;
    logic ev, ee;
    logic [63:0] act, expv;
    for (int ch = 0; ch < N_ADC; ch++) begin
      e_rst[ch] = !win(rst_s[ch], rst_e[ch], cyc);
      e_cal[ch] = win(cal_s[ch], cal_e[ch], cyc);
    end
    ev = 1'b0;
    ee = 1'b0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      ev = sbq[0].valid;
      ee = sbq[0].err;
      void'(sbq.pop_front());
    end
    expv = 64'({e_rst, e_cal, !win(dtu_s, dtu_e, cyc), !win(i2c_s, i2c_e, cyc),
                !win(atu_s, atu_e, cyc), (cyc >= sync_t) ? sync_new : sync_prev,
                cyc == flush_t, cyc == pll_t, win(tp_s, tp_e, cyc), cyc == bc0_t,
                ev, ee, last_op_m, 8'(errc_m)});
    act = 64'({adc_rst_b, adc_cal, dtu_rst_b, i2c_rst_b, atu_rst_b, dtu_sync_mode,
               dtu_flush, pll_lock_start, catia_tp, bc0_mark, cmd_valid, cmd_err,
               last_op, err_count});
    chk("outputs", act, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    serial_in = 1'b0;
    rst = 1'b1;
    model_clear();
    idle(2);
    rst = 1'b0;
  endtask

  // Expected effects of a frame decoded at edge d.
  task automatic model_decode(input int d, input logic [3:0] op, input logic [3:0] arg,
                              input logic par_ok);
    logic ok;
    ok = par_ok && (op <= 4'hB) &&
         !(((op == 4'h1) || (op == 4'h2)) && (arg[N_ADC-1:0] == '0));
    if (!ok) begin
      if (errc_m < 255) errc_m++;
      sbq.push_back('{d, 1'b0, 1'b1});
      return;
    end
    last_op_m = op;
    sbq.push_back('{d, 1'b1, 1'b0});
    case (op)
      4'h1: for (int ch = 0; ch < N_ADC; ch++)
              if (arg[ch]) begin rst_s[ch] = d; rst_e[ch] = d + RST_LEN; end
      4'h2: for (int ch = 0; ch < N_ADC; ch++)
              if (arg[ch]) begin cal_s[ch] = d; cal_e[ch] = d + CAL_LEN; end
      4'h3: begin dtu_s = d; dtu_e = d + RST_LEN; end
      4'h4: begin i2c_s = d; i2c_e = d + RST_LEN; end
      4'h5: begin atu_s = d; atu_e = d + RST_LEN; end
      4'h6: begin sync_prev = sync_new; sync_new = 1'b1; sync_t = d; end
      4'h7: begin sync_prev = sync_new; sync_new = 1'b0; sync_t = d; end
      4'h8: flush_t = d;
      4'h9: pll_t = d;
      4'hA: if (tp_len != 8'd0 && !win(tp_s, tp_e, d - 1)) begin
              tp_s = d; tp_e = d + int'(tp_len);
            end
      4'hB: bc0_t = d;
      default: ;
    endcase
  endtask

  task automatic send_frame(input logic [3:0] op, input logic [3:0] arg, input logic bad_par);
    logic [9:0] f;
    f[9]   = 1'b1;
    f[8:5] = op;
    f[4:1] = arg;
    f[0]   = (^{1'b1, op, arg}) ^ bad_par;
    for (int i = 9; i >= 0; i--) begin
      serial_in = f[i];
      tick();
    end
    serial_in = 1'b0;
    model_decode(cyc + 1, op, arg, ~^f);
  endtask

  initial begin
    model_clear();
    do_reset();
    idle(2);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_adc_rst_b", 64'(adc_rst_b), 64'd3);

    // ADC reset on channel 1 only, then the same frame with corrupt parity.
    send_frame(4'h1, 4'b0010, 1'b0);
    idle(12);
    send_frame(4'h1, 4'b0010, 1'b1);
    idle(4);
    chk("err_after_bad_parity", 64'(err_count), 64'd1);
    chk("last_op_kept", 64'(last_op), 64'h1);

    // Reject: mask only above N_ADC, reserved opcode, zero CAL mask.
    send_frame(4'h1, 4'b1100, 1'b0);
    send_frame(4'hC, 4'h0, 1'b0);
    send_frame(4'h2, 4'h0, 1'b0);
    idle(3);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      if (i % 3 == 0) send_frame(4'hF, 4'h3, 1'b0);
      else            send_frame(4'h8, 4'h0, 1'b1);
    end
    idle(2);
    chk("err_saturated", 64'(err_count), 64'd255);

    // Test pulse: short pulses, long pulse with back-to-back TP ignored, zero length.
    tp_len = 8'd5;
    send_frame(4'hA, 4'h0, 1'b0);
    send_frame(4'hA, 4'h0, 1'b0);
    idle(8);
    tp_len = 8'd15;
    send_frame(4'hA, 4'h0, 1'b0);
    send_frame(4'hA, 4'h0, 1'b0);
    idle(18);
    tp_len = 8'd0;
    send_frame(4'hA, 4'h0, 1'b0);
    idle(3);

    // CAL on both channels, then retrigger channel 0 while still active.
    send_frame(4'h2, 4'b0011, 1'b0);
    send_frame(4'h2, 4'b0001, 1'b0);
    idle(15);

    // Level and strobes back-to-back, then the remaining resets.
    send_frame(4'h6, 4'h0, 1'b0);
    send_frame(4'h8, 4'h0, 1'b0);
    send_frame(4'hB, 4'h0, 1'b0);
    send_frame(4'h9, 4'h0, 1'b0);
    idle(4);
    send_frame(4'h7, 4'h0, 1'b0);
    send_frame(4'h0, 4'h0, 1'b0);
    send_frame(4'h4, 4'h0, 1'b0);
    send_frame(4'h5, 4'h0, 1'b0);
    send_frame(4'h1, 4'b0011, 1'b0);
    idle(12);

    // Reset mid DTU pulse and mid frame; the partial frame must vanish.
    send_frame(4'h3, 4'h0, 1'b0);
    idle(1);
    serial_in = 1'b1; tick();
    serial_in = 1'b0; tick();
    serial_in = 1'b0; tick();
    serial_in = 1'b1; tick();
    do_reset();
    chk("dtu_rst_b_after_rst", 64'(dtu_rst_b), 64'd1);
    send_frame(4'h0, 4'h0, 1'b0);
    idle(2);
    chk("nop_after_rst_last_op", 64'(last_op), 64'h0);
    chk("nop_after_rst_err", 64'(err_count), 64'd0);
    send_frame(4'h3, 4'h0, 1'b0);
    idle(12);

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
